// File: rtl/alu_pkg.sv
// alu_pkg: ALUFun codes, datapath widths and the controller state encoding
// shared by the ALU sharing controller and its arbiter.
`default_nettype none

package alu_pkg;

  localparam int ALU_W  = 32;
  localparam int ALU_FW = 6;

  localparam logic [ALU_FW-1:0] FUN_ADD   = 6'b000000;
  localparam logic [ALU_FW-1:0] FUN_SUB   = 6'b000001;
  localparam logic [ALU_FW-1:0] FUN_AND   = 6'b011000;
  localparam logic [ALU_FW-1:0] FUN_OR    = 6'b011110;
  localparam logic [ALU_FW-1:0] FUN_XOR   = 6'b010110;
  localparam logic [ALU_FW-1:0] FUN_NOR   = 6'b010001;
  localparam logic [ALU_FW-1:0] FUN_PASSA = 6'b011010;
  localparam logic [ALU_FW-1:0] FUN_SLL   = 6'b100000;
  localparam logic [ALU_FW-1:0] FUN_SRL   = 6'b100001;
  localparam logic [ALU_FW-1:0] FUN_SRA   = 6'b100011;
  localparam logic [ALU_FW-1:0] FUN_EQ    = 6'b110011;
  localparam logic [ALU_FW-1:0] FUN_NEQ   = 6'b110001;
  localparam logic [ALU_FW-1:0] FUN_LT    = 6'b110101;
  localparam logic [ALU_FW-1:0] FUN_LEZ   = 6'b111101;
  localparam logic [ALU_FW-1:0] FUN_LTZ   = 6'b111011;
  localparam logic [ALU_FW-1:0] FUN_GTZ   = 6'b111111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// rr_arb2: two-way combinational round-robin pick; ptr chooses the winner
// only when both requesters are valid.
`default_nettype none

module rr_arb2 (
  input  logic v0,
  input  logic v1,
  input  logic ptr,
  output logic grant,
  output logic grant_valid
);

  always_comb begin
    grant_valid = v0 | v1;
    if (v0 && v1) begin
      grant = ptr;
    end else begin
      grant = v1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: time-shares one combinational ALU between two requesters,
// registering operands for a full cycle and returning Z on a valid/ready channel.
`default_nettype none

module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int W  = ALU_W,
  parameter int FW = ALU_FW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          r0_valid,
  output logic          r0_ready,
  input  logic [W-1:0]  r0_a,
  input  logic [W-1:0]  r0_b,
  input  logic          r0_sign,
  input  logic [FW-1:0] r0_fun,
  input  logic          r1_valid,
  output logic          r1_ready,
  input  logic [W-1:0]  r1_a,
  input  logic [W-1:0]  r1_b,
  input  logic          r1_sign,
  input  logic [FW-1:0] r1_fun,
  output logic          rsp0_valid,
  output logic          rsp1_valid,
  input  logic          rsp0_ready,
  input  logic          rsp1_ready,
  output logic [W-1:0]  rsp_z,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  output logic          alu_sign,
  output logic [FW-1:0] alu_fun,
  input  logic [W-1:0]  alu_z,
  output logic          busy
);

  state_t state;
  state_t state_nxt;
  logic   ptr;
  logic   grant;
  logic   arb_idx;
  logic   arb_vld;
  logic   accept;

  rr_arb2 u_arb (
    .v0          (r0_valid),
    .v1          (r1_valid),
    .ptr         (ptr),
    .grant       (arb_idx),
    .grant_valid (arb_vld)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arb_vld) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (grant ? rsp1_ready : rsp0_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Ready is gated by reset so nothing looks accepted while reset is held.
  always_comb begin
    accept     = (state == IDLE) && arb_vld && reset;
    r0_ready   = accept && !arb_idx;
    r1_ready   = accept && arb_idx;
    rsp0_valid = (state == RESP) && !grant;
    rsp1_valid = (state == RESP) && grant;
    busy       = (state != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr      <= 1'b0;
      grant    <= 1'b0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_sign <= 1'b0;
      alu_fun  <= '0;
      rsp_z    <= '0;
    end else begin
      if (accept) begin
        grant    <= arb_idx;
        alu_a    <= arb_idx ? r1_a    : r0_a;
        alu_b    <= arb_idx ? r1_b    : r0_b;
        alu_sign <= arb_idx ? r1_sign : r0_sign;
        alu_fun  <= arb_idx ? r1_fun  : r0_fun;
      end
      if (state == EXEC) begin
        rsp_z <= alu_z;
        ptr   <= ~grant;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed vector table plus hand sequences for backpressure,
// fairness and mid-operation reset; a small ALU model drives alu_z.
`default_nettype none

module tb_alu_share_ctrl;
  import alu_pkg::*;

  logic        clk, reset;
  logic        r0_valid, r0_ready, r0_sign, r1_valid, r1_ready, r1_sign;
  logic [31:0] r0_a, r0_b, r1_a, r1_b, rsp_z, alu_a, alu_b, alu_z;
  logic [5:0]  r0_fun, r1_fun, alu_fun;
  logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready, alu_sign, busy;

  int checks = 0;
  int errors = 0;

  alu_share_ctrl #(.W(32), .FW(6)) dut (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b),
    .r0_sign(r0_sign), .r0_fun(r0_fun),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b),
    .r1_sign(r1_sign), .r1_fun(r1_fun),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready), .rsp_z(rsp_z),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sign(alu_sign), .alu_fun(alu_fun),
    .alu_z(alu_z), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU stand-in; undefined codes return a marker value.
  function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic s, input logic [5:0] f);
    logic lt;
    lt = s ? ($signed(a) < $signed(b)) : (a < b);
    case (f)
      FUN_ADD:   return a + b;
      FUN_SUB:   return a - b;
      FUN_AND:   return a & b;
      FUN_OR:    return a | b;
      FUN_XOR:   return a ^ b;
      FUN_NOR:   return ~(a | b);
      FUN_PASSA: return a;
      FUN_SLL:   return b << a[4:0];
      FUN_SRL:   return b >> a[4:0];
      FUN_SRA:   return $unsigned($signed(b) >>> a[4:0]);
      FUN_EQ:    return {31'd0, a == b};
      FUN_NEQ:   return {31'd0, a != b};
      FUN_LT:    return {31'd0, lt};
      FUN_LEZ:   return {31'd0, $signed(a) <= 0};
      FUN_LTZ:   return {31'd0, $signed(a) < 0};
      FUN_GTZ:   return {31'd0, $signed(a) > 0};
      default:   return 32'hDEADBEEF;
    endcase
  endfunction

  always_comb alu_z = alu_model(alu_a, alu_b, alu_sign, alu_fun);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        v0, v1;
    logic [31:0] a0, b0;
    logic        s0;
    logic [5:0]  f0;
    logic [31:0] a1, b1;
    logic        s1;
    logic [5:0]  f1;
    logic        g;
    logic [31:0] z;
  } vec_t;

  function automatic vec_t mk(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                              input logic s0, input logic [5:0] f0,
                              input logic v1, input logic [31:0] a1, input logic [31:0] b1,
                              input logic s1, input logic [5:0] f1,
                              input logic g, input logic [31:0] z);
    vec_t v;
    v.v0 = v0; v.a0 = a0; v.b0 = b0; v.s0 = s0; v.f0 = f0;
    v.v1 = v1; v.a1 = a1; v.b1 = b1; v.s1 = s1; v.f1 = f1;
    v.g = g; v.z = z;
    return v;
  endfunction

  vec_t tbl[10];

  // Runs one full operation starting at a negedge in IDLE; ends at a negedge in IDLE.
  task automatic apply(input vec_t v, input string t);
    r0_valid = v.v0; r0_a = v.a0; r0_b = v.b0; r0_sign = v.s0; r0_fun = v.f0;
    r1_valid = v.v1; r1_a = v.a1; r1_b = v.b1; r1_sign = v.s1; r1_fun = v.f1;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #1;
    chk({t, "_r0_ready"}, {31'd0, r0_ready}, {31'd0, !v.g});
    chk({t, "_r1_ready"}, {31'd0, r1_ready}, {31'd0, v.g});
    @(negedge clk);
    r0_valid = 1'b0; r1_valid = 1'b0;
    chk({t, "_exec_busy"}, {31'd0, busy}, 32'd1);
    chk({t, "_alu_a"}, alu_a, v.g ? v.a1 : v.a0);
    chk({t, "_alu_b"}, alu_b, v.g ? v.b1 : v.b0);
    chk({t, "_alu_sign"}, {31'd0, alu_sign}, {31'd0, v.g ? v.s1 : v.s0});
    chk({t, "_alu_fun"}, {26'd0, alu_fun}, {26'd0, v.g ? v.f1 : v.f0});
    chk({t, "_exec_rspv"}, {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    @(negedge clk);
    chk({t, "_rsp_valid"}, {30'd0, rsp1_valid, rsp0_valid}, v.g ? 32'd2 : 32'd1);
    chk({t, "_rsp_z"}, rsp_z, v.z);
    @(negedge clk);
    chk({t, "_done_busy"}, {31'd0, busy}, 32'd0);
    chk({t, "_done_rspv"}, {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_cyc[6];
    logic acc_g[6];
    int nacc;

    tbl[0] = mk(1, 32'd10, 32'd3, 0, FUN_SUB, 1, 32'd4, 32'd1, 0, FUN_SLL, 0, 32'd7);
    tbl[1] = mk(1, 32'd10, 32'd3, 0, FUN_SUB, 1, 32'd4, 32'd1, 0, FUN_SLL, 1, 32'h10);
    tbl[2] = mk(1, 32'd10, 32'd3, 0, FUN_SUB, 1, 32'd4, 32'd1, 0, FUN_SLL, 0, 32'd7);
    tbl[3] = mk(1, 32'd5, 32'd7, 0, FUN_ADD, 0, 32'd0, 32'd0, 0, FUN_ADD, 0, 32'd12);
    tbl[4] = mk(0, 32'd0, 32'd0, 0, FUN_ADD, 1, 32'hFFFFFFFF, 32'd1, 1, FUN_LT, 1, 32'd1);
    tbl[5] = mk(1, 32'hFF00FF00, 32'h0FF00FF0, 0, FUN_XOR, 1, 32'd0, 32'd0, 0, FUN_NOR,
                0, 32'hF0F0F0F0);
    tbl[6] = mk(1, 32'd5, 32'd5, 0, FUN_EQ, 1, 32'd4, 32'h80000000, 0, FUN_SRA,
                1, 32'hF8000000);
    tbl[7] = mk(1, 32'h80000000, 32'd0, 1, FUN_GTZ, 0, 32'd0, 32'd0, 0, FUN_ADD, 0, 32'd0);
    tbl[8] = mk(0, 32'd0, 32'd0, 0, FUN_ADD, 1, 32'hFFFFFFFF, 32'd1, 0, FUN_LT, 1, 32'd0);
    tbl[9] = mk(1, 32'd3, 32'd4, 0, 6'b101010, 0, 32'd0, 32'd0, 0, FUN_ADD, 0, 32'hDEADBEEF);

    reset = 1'b0;
    r0_valid = 1'b1; r0_a = 32'd1; r0_b = 32'd2; r0_sign = 1'b0; r0_fun = FUN_ADD;
    r1_valid = 1'b1; r1_a = 32'd3; r1_b = 32'd4; r1_sign = 1'b0; r1_fun = FUN_ADD;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {30'd0, r1_ready, r0_ready}, 32'd0);
    chk("rst_rspv", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_fun", {26'd0, alu_fun}, 32'd0);
    chk("rst_rsp_z", rsp_z, 32'd0);
    r0_valid = 1'b0; r1_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      apply(tbl[i], $sformatf("v%0d", i));
    end

    // Backpressure on requester 1 while requester 0 waits.
    r1_valid = 1'b1; r1_a = 32'hFFFFFFFF; r1_b = 32'd1; r1_sign = 1'b1; r1_fun = FUN_LT;
    r0_a = 32'd1; r0_b = 32'd2; r0_sign = 1'b0; r0_fun = FUN_ADD;
    rsp0_ready = 1'b1; rsp1_ready = 1'b0;
    #1;
    chk("bp_accept", {31'd0, r1_ready}, 32'd1);
    @(negedge clk);
    r1_valid = 1'b0; r0_valid = 1'b1;
    chk("bp_exec_r0_ready", {31'd0, r0_ready}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d_rspv", k), {30'd0, rsp1_valid, rsp0_valid}, 32'd2);
      chk($sformatf("bp_hold%0d_z", k), rsp_z, 32'd1);
      chk($sformatf("bp_hold%0d_r0_ready", k), {31'd0, r0_ready}, 32'd0);
      chk($sformatf("bp_hold%0d_busy", k), {31'd0, busy}, 32'd1);
    end
    rsp1_ready = 1'b1;
    #1;
    chk("bp_handshake_r0_ready", {31'd0, r0_ready}, 32'd0);
    @(negedge clk);
    chk("bp_release_rspv", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    chk("bp_next_r0_ready", {31'd0, r0_ready}, 32'd1);
    @(negedge clk);
    r0_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_rspv", {30'd0, rsp1_valid, rsp0_valid}, 32'd1);
    chk("bp_next_z", rsp_z, 32'd3);
    @(negedge clk);

    // Fairness from a fresh reset: both requesters valid continuously.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    r0_valid = 1'b1; r0_a = 32'd5; r0_b = 32'd7; r0_fun = FUN_ADD;
    r1_valid = 1'b1; r1_a = 32'd10; r1_b = 32'd3; r1_fun = FUN_SUB;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    nacc = 0;
    for (int c = 0; c < 40 && nacc < 6; c++) begin
      #1;
      if (r0_ready || r1_ready) begin
        acc_cyc[nacc] = c;
        acc_g[nacc] = r1_ready;
        nacc++;
      end
      @(negedge clk);
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
    chk("fair_accept_count", nacc, 32'd6);
    for (int k = 0; k < nacc; k++) begin
      chk($sformatf("fair_grant%0d", k), {31'd0, acc_g[k]}, k % 2);
      if (k > 0) chk($sformatf("fair_gap%0d", k), acc_cyc[k] - acc_cyc[k-1], 32'd3);
    end
    repeat (4) @(negedge clk);

    // Reset asserted during EXEC discards the operation.
    r0_valid = 1'b1; r0_a = 32'h0000F0F0; r0_b = 32'h0000FF00; r0_sign = 1'b0;
    r0_fun = FUN_AND;
    #1;
    chk("mid_accept", {31'd0, r0_ready}, 32'd1);
    @(negedge clk);
    r0_valid = 1'b0;
    chk("mid_exec_busy", {31'd0, busy}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_alu_a", alu_a, 32'd0);
    chk("mid_rst_alu_b", alu_b, 32'd0);
    chk("mid_rst_alu_fun", {26'd0, alu_fun}, 32'd0);
    chk("mid_rst_rsp_z", rsp_z, 32'd0);
    chk("mid_rst_rspv", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("mid_after%0d_rspv", k), {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    end
    apply(mk(0, 32'd0, 32'd0, 0, FUN_ADD, 1, 32'h10, 32'h20, 0, FUN_ADD, 1, 32'h30), "post_r1");
    apply(mk(1, 32'd1, 32'd2, 0, FUN_OR, 1, 32'd0, 32'd0, 0, FUN_ADD, 0, 32'd3), "post_r0");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
